// File: rtl/ren_tile_walker_if.sv
`default_nettype none
// ============================================================================
//  Module      : ren_tile_walker_if
//  Description : Triangle setup intake and tile request bus of the tile
//                walker. The slave side is the walker and the master side is
//                the setup / fragment-shader environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ren_tile_walker_if #(
  parameter int COORD_W = 16
);
  // Triangle intake
  logic               i_en;
  logic               i_valid;
  logic               o_ready;
  logic [COORD_W-1:0] i_bbox_xmin;
  logic [COORD_W-1:0] i_bbox_ymin;
  logic [COORD_W-1:0] i_bbox_xmax;
  logic [COORD_W-1:0] i_bbox_ymax;
  logic [15:0]        i_tile_size;
  logic [65:0]        i_cr_delta;
  logic [65:0]        i_cg_delta;
  logic [65:0]        i_cb_delta;
  logic [65:0]        i_z_delta;
  // Tile request to the fragment shader
  logic               o_valid;
  logic               i_ack;
  logic [21:0]        o_tile_x;
  logic [21:0]        o_tile_y;
  logic [15:0]        o_tile_size;
  logic [65:0]        o_cr_delta;
  logic [65:0]        o_cg_delta;
  logic [65:0]        o_cb_delta;
  logic [65:0]        o_z_delta;
  logic               o_done;
  logic [15:0]        o_tile_cnt;

  modport slave (
    input  i_en, i_valid, i_bbox_xmin, i_bbox_ymin, i_bbox_xmax, i_bbox_ymax,
           i_tile_size, i_cr_delta, i_cg_delta, i_cb_delta, i_z_delta, i_ack,
    output o_ready, o_valid, o_tile_x, o_tile_y, o_tile_size, o_cr_delta,
           o_cg_delta, o_cb_delta, o_z_delta, o_done, o_tile_cnt
  );

  modport master (
    output i_en, i_valid, i_bbox_xmin, i_bbox_ymin, i_bbox_xmax, i_bbox_ymax,
           i_tile_size, i_cr_delta, i_cg_delta, i_cb_delta, i_z_delta, i_ack,
    input  o_ready, o_valid, o_tile_x, o_tile_y, o_tile_size, o_cr_delta,
           o_cg_delta, o_cb_delta, o_z_delta, o_done, o_tile_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ren_tile_walker.sv
`default_nettype none
// ============================================================================
//  Module      : ren_tile_walker
//  Description : Walks a triangle's inclusive pixel bounding box in
//                tile-aligned steps, row-major with x fastest, issuing one
//                tile request per fragment-shader acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ren_tile_walker #(
  parameter int COORD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ren_tile_walker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [COORD_W-1:0] c_one = COORD_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [COORD_W-1:0] r_xmin, r_ymin, r_xmax, r_ymax;
  logic [COORD_W-1:0] r_start_x, r_cur_x, r_cur_y;
  logic [15:0]        r_size;
  logic [15:0]        r_cnt;
  logic [65:0]        r_cr, r_cg, r_cb, r_z;

  logic               w_ready, w_valid, w_done;
  logic               w_accept, w_xfer;
  logic [15:0]        w_size_legal;
  logic [COORD_W:0]   w_size_ext;
  logic [COORD_W-1:0] w_mask;
  logic [COORD_W:0]   w_next_x, w_next_y;
  logic               w_x_beyond, w_y_beyond, w_empty;

  // Unsupported tile sizes fall back to the largest legal tile
  always_comb begin
    case (bus.i_tile_size)
      16'd1, 16'd2, 16'd4, 16'd8, 16'd16: w_size_legal = bus.i_tile_size;
      default:                            w_size_legal = 16'd16;
    endcase
  end

  // Stepping is done one bit wider than a coordinate so a step past the
  // top of the coordinate space reads as "beyond max" instead of wrapping
  assign w_size_ext = (COORD_W+1)'(r_size);
  assign w_mask     = ~(w_size_ext[COORD_W-1:0] - c_one);
  assign w_next_x   = {1'b0, r_cur_x} + w_size_ext;
  assign w_next_y   = {1'b0, r_cur_y} + w_size_ext;
  assign w_x_beyond = (w_next_x > {1'b0, r_xmax});
  assign w_y_beyond = (w_next_y > {1'b0, r_ymax});
  assign w_empty    = (r_xmin > r_xmax) || (r_ymin > r_ymax);

  assign w_accept   = w_ready && bus.i_en && bus.i_valid;
  assign w_xfer     = w_valid && bus.i_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_en && bus.i_valid) begin
          w_state_nxt = S_ALIGN;
        end
      end
      S_ALIGN: begin
        w_state_nxt = w_empty ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        w_valid = 1'b1;
        if (bus.i_ack && w_x_beyond && w_y_beyond) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Triangle latch, tile cursor and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xmin    <= '0;
      r_ymin    <= '0;
      r_xmax    <= '0;
      r_ymax    <= '0;
      r_size    <= '0;
      r_cr      <= '0;
      r_cg      <= '0;
      r_cb      <= '0;
      r_z       <= '0;
      r_start_x <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_xmin <= bus.i_bbox_xmin;
        r_ymin <= bus.i_bbox_ymin;
        r_xmax <= bus.i_bbox_xmax;
        r_ymax <= bus.i_bbox_ymax;
        r_size <= w_size_legal;
        r_cr   <= bus.i_cr_delta;
        r_cg   <= bus.i_cg_delta;
        r_cb   <= bus.i_cb_delta;
        r_z    <= bus.i_z_delta;
        r_cnt  <= '0;
      end
      if (r_state == S_ALIGN) begin
        r_start_x <= r_xmin & w_mask;
        r_cur_x   <= r_xmin & w_mask;
        r_cur_y   <= r_ymin & w_mask;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + 16'd1;
        // The cursor is left alone on the final tile; it is not shown again
        if (!w_x_beyond) begin
          r_cur_x <= w_next_x[COORD_W-1:0];
        end else if (!w_y_beyond) begin
          r_cur_x <= r_start_x;
          r_cur_y <= w_next_y[COORD_W-1:0];
        end
      end
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = w_valid;
  assign bus.o_done      = w_done;
  assign bus.o_tile_x    = 22'(r_cur_x);
  assign bus.o_tile_y    = 22'(r_cur_y);
  assign bus.o_tile_size = r_size;
  assign bus.o_cr_delta  = r_cr;
  assign bus.o_cg_delta  = r_cg;
  assign bus.o_cb_delta  = r_cb;
  assign bus.o_z_delta   = r_z;
  assign bus.o_tile_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ren_tile_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ren_tile_walker
//  Description : Self-checking bench for ren_tile_walker. A tile-list model
//                predicts every cycle's outputs; directed cases pin literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ren_tile_walker;

  typedef struct {
    int x;
    int y;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  ren_tile_walker_if #(.COORD_W(16)) bus ();

  ren_tile_walker #(.COORD_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: the full tile list of a triangle, computed up front
  // -------------------------------------------------------------------------
  tile_t model_q[$];

  function automatic int eff_size(input int s);
    return (s == 1 || s == 2 || s == 4 || s == 8 || s == 16) ? s : 16;
  endfunction

  function automatic void build(input int xmin, input int ymin, input int xmax,
                                input int ymax, input int s_in);
    int s;
    tile_t t;
    s = eff_size(s_in);
    model_q.delete();
    if (xmin > xmax || ymin > ymax) return;
    for (int y = (ymin / s) * s; y <= ymax; y += s) begin
      for (int x = (xmin / s) * s; x <= xmax; x += s) begin
        t.x = x;
        t.y = y;
        model_q.push_back(t);
      end
    end
  endfunction

  // -------------------------------------------------------------------------
  // Per-cycle compare against the model
  // -------------------------------------------------------------------------
  tile_t       exp_q[$];
  tile_t       obs_log[$];
  bit          m_busy = 1'b0;
  bit          m_after_rst = 1'b0;
  int          m_k = 0;
  int          m_cnt = 0;
  int          m_first_valid_k = -1;
  int          m_done_k = -1;
  int          done_count = 0;
  logic [15:0] m_size = '0;
  logic [65:0] m_cr = '0, m_cg = '0, m_cb = '0, m_z = '0;

  always @(negedge clk) begin
    bit idle_now;
    idle_now = m_after_rst || !m_busy;
    if (m_after_rst) begin
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_cnt", bus.o_tile_cnt, 0);
      chk("rst_tile_x", bus.o_tile_x, 0);
      chk("rst_tile_y", bus.o_tile_y, 0);
      chk("rst_size", bus.o_tile_size, 0);
      chk("rst_deltas", bus.o_cr_delta | bus.o_cg_delta | bus.o_cb_delta | bus.o_z_delta, 0);
      m_after_rst = 1'b0;
    end else if (!m_busy) begin
      chk("idle_ready", bus.o_ready, 1);
      chk("idle_valid", bus.o_valid, 0);
      chk("idle_done", bus.o_done, 0);
      chk("idle_cnt", bus.o_tile_cnt, 16'(m_cnt));
    end else begin
      m_k++;
      chk("busy_ready", bus.o_ready, 0);
      chk("busy_cnt", bus.o_tile_cnt, 16'(m_cnt));
      if (m_k == 1) begin
        chk("align_valid", bus.o_valid, 0);
        chk("align_done", bus.o_done, 0);
      end else if (exp_q.size() > 0) begin
        chk("issue_valid", bus.o_valid, 1);
        chk("issue_done", bus.o_done, 0);
        chk("tile_x", bus.o_tile_x, 66'(exp_q[0].x));
        chk("tile_y", bus.o_tile_y, 66'(exp_q[0].y));
        chk("tile_size", bus.o_tile_size, m_size);
        chk("cr_delta", bus.o_cr_delta, m_cr);
        chk("cg_delta", bus.o_cg_delta, m_cg);
        chk("cb_delta", bus.o_cb_delta, m_cb);
        chk("z_delta", bus.o_z_delta, m_z);
        if (m_first_valid_k < 0 && bus.o_valid) m_first_valid_k = m_k;
        if (bus.i_ack && !rst) begin
          obs_log.push_back(exp_q.pop_front());
          m_cnt++;
        end
      end else begin
        chk("end_done", bus.o_done, 1);
        chk("end_valid", bus.o_valid, 0);
        if (bus.o_done) done_count++;
        m_done_k = m_k;
        m_busy = 1'b0;
      end
    end

    // What the coming rising edge will do
    if (rst) begin
      m_busy = 1'b0;
      m_after_rst = 1'b1;
      m_cnt = 0;
      exp_q.delete();
    end else if (idle_now && bus.i_en && bus.i_valid) begin
      build(int'(bus.i_bbox_xmin), int'(bus.i_bbox_ymin), int'(bus.i_bbox_xmax),
            int'(bus.i_bbox_ymax), int'(bus.i_tile_size));
      exp_q = model_q;
      obs_log.delete();
      m_busy = 1'b1;
      m_k = 0;
      m_cnt = 0;
      m_first_valid_k = -1;
      m_done_k = -1;
      m_size = 16'(eff_size(int'(bus.i_tile_size)));
      m_cr = bus.i_cr_delta;
      m_cg = bus.i_cg_delta;
      m_cb = bus.i_cb_delta;
      m_z  = bus.i_z_delta;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  function automatic logic [65:0] rnd66();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive_tri(input int xmin, input int ymin, input int xmax,
                           input int ymax, input int s);
    bus.i_bbox_xmin = 16'(xmin);
    bus.i_bbox_ymin = 16'(ymin);
    bus.i_bbox_xmax = 16'(xmax);
    bus.i_bbox_ymax = 16'(ymax);
    bus.i_tile_size = 16'(s);
    bus.i_cr_delta  = rnd66();
    bus.i_cg_delta  = rnd66();
    bus.i_cb_delta  = rnd66();
    bus.i_z_delta   = rnd66();
  endtask

  // Present one triangle for exactly one edge while the walker is idle
  task automatic send(input int xmin, input int ymin, input int xmax,
                      input int ymax, input int s);
    drive_tri(xmin, ymin, xmax, ymax, s);
    bus.i_en    = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_en    = 1'b0;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (bus.o_ready) break;
    end
    chk("idle_timeout", (i < maxc), 1);
  endtask

  task automatic chk_log(input string nm, input int n, input int xs[4], input int ys[4]);
    tile_t t;
    chk({nm, "_ntiles"}, 66'(obs_log.size()), 66'(n));
    for (int i = 0; i < n; i++) begin
      t.x = -1;
      t.y = -1;
      if (i < obs_log.size()) t = obs_log[i];
      chk({nm, "_x"}, 66'(t.x), 66'(xs[i]));
      chk({nm, "_y"}, 66'(t.y), 66'(ys[i]));
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int sizes[10] = '{1, 2, 4, 8, 16, 0, 3, 5, 32, 100};
    int dc, hx, hy, base, span;

    bus.i_en = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ack = 1'b0;
    drive_tri(0, 0, 0, 0, 1);

    // Hand-computed expectations for the model itself
    build(0, 0, 15, 15, 8);
    chk("model_4tiles_n", 66'(model_q.size()), 4);
    chk("model_4tiles_last", 66'(model_q[3].x + 1000 * model_q[3].y), 8008);
    build(5, 3, 9, 3, 5);
    chk("model_size5_n", 66'(model_q.size()), 1);
    build(65528, 0, 65535, 0, 16);
    chk("model_top_x", 66'(model_q[0].x), 65520);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", bus.o_ready, 1);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_cnt", bus.o_tile_cnt, 0);

    // 16x16 box, 8-pixel tiles, acknowledge held high
    bus.i_ack = 1'b1;
    dc = done_count;
    send(0, 0, 15, 15, 8);
    wait_idle(50);
    chk_log("box16", 4, '{0, 8, 0, 8}, '{0, 0, 8, 8});
    chk("box16_cnt", bus.o_tile_cnt, 4);
    chk("box16_first_lat", 66'(m_first_valid_k), 2);
    chk("box16_done_lat", 66'(m_done_k), 6);
    chk("box16_done_count", 66'(done_count - dc), 1);

    // Unaligned thin box, then an illegal tile size
    send(5, 3, 9, 3, 4);
    wait_idle(50);
    chk_log("thin4", 2, '{4, 8, 0, 0}, '{0, 0, 0, 0});
    chk("thin4_cnt", bus.o_tile_cnt, 2);
    send(5, 3, 9, 3, 5);
    wait_idle(50);
    chk_log("size5", 1, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    chk("size5_cnt", bus.o_tile_cnt, 1);

    // Empty box: only a done pulse, two cycles after acceptance
    dc = done_count;
    send(10, 0, 2, 0, 4);
    wait_idle(50);
    chk("empty_ntiles", 66'(obs_log.size()), 0);
    chk("empty_done_lat", 66'(m_done_k), 2);
    chk("empty_done_count", 66'(done_count - dc), 1);
    chk("empty_cnt", bus.o_tile_cnt, 0);

    // Back-pressure: outputs frozen while acknowledge is low
    bus.i_ack = 1'b0;
    send(0, 0, 7, 0, 4);
    @(posedge clk); #1;
    chk("stall_valid0", bus.o_valid, 1);
    hx = int'(bus.o_tile_x);
    hy = int'(bus.o_tile_y);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid3", bus.o_valid, 1);
    chk("stall_x", bus.o_tile_x, 66'(hx));
    chk("stall_y", bus.o_tile_y, 66'(hy));
    chk("stall_cnt", bus.o_tile_cnt, 0);
    bus.i_ack = 1'b1;
    @(posedge clk); #1;
    chk("stall_adv_x", bus.o_tile_x, 4);
    wait_idle(50);
    chk_log("stall", 2, '{0, 4, 0, 0}, '{0, 0, 0, 0});

    // Top of coordinate space: no wrap
    send(65528, 0, 65535, 0, 16);
    wait_idle(50);
    chk_log("top", 1, '{65520, 0, 0, 0}, '{0, 0, 0, 0});

    // Reset in the middle of a walk
    dc = done_count;
    send(0, 0, 15, 15, 8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_ready", bus.o_ready, 1);
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_cnt", bus.o_tile_cnt, 0);
    chk("midrst_ntiles", 66'(obs_log.size()), 2);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 66'(done_count - dc), 0);

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 599) == 0);
      bus.i_en    = ($urandom_range(0, 3) != 0);
      bus.i_valid = ($urandom_range(0, 2) == 0);
      bus.i_ack   = ($urandom_range(0, 9) < 7);
      base = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65500, 65535))
                                         : int'($urandom_range(0, 65535));
      span = $urandom_range(0, 20);
      if (base + span > 65535) span = 65535 - base;
      hx = base;
      hy = int'($urandom_range(0, 65500));
      if ($urandom_range(0, 7) == 0 && base > 0) begin
        drive_tri(hx, hy, hx - 1, hy + span, sizes[$urandom_range(0, 9)]);
      end else begin
        drive_tri(hx, hy, hx + span, hy + int'($urandom_range(0, 20)),
                  sizes[$urandom_range(0, 9)]);
      end
    end
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_en = 1'b0;
    bus.i_ack = 1'b1;
    wait_idle(2000);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ren_tile_walker.md
REN_TILE_WALKER -- requirements
Module: ren_tile_walker

Interface
REQ-001 Parameter COORD_W, default 16, integer pixel coordinate width of bounding-box inputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_en  input  1  enables acceptance of a new triangle.
REQ-005 i_valid  input  1  triangle setup record valid.
REQ-006 o_ready  output  1  walker idle and able to accept a triangle.
REQ-007 i_bbox_xmin, i_bbox_ymin, i_bbox_xmax, i_bbox_ymax  input  COORD_W each  inclusive pixel bounding box.
REQ-008 i_tile_size  input  16  tile edge in pixels, legal values 1, 2, 4, 8, 16.
REQ-009 i_cr_delta, i_cg_delta, i_cb_delta, i_z_delta  input  66 each  per-triangle attribute deltas (3 x 22-bit FP).
REQ-010 o_valid  output  1  tile request valid to fragment shader.
REQ-011 i_ack  input  1  fragment shader accepts current tile.
REQ-012 o_tile_x, o_tile_y  output  22 each  tile origin, integer in [COORD_W-1:0], upper bits zero.
REQ-013 o_tile_size  output  16  latched tile size.
REQ-014 o_cr_delta, o_cg_delta, o_cb_delta, o_z_delta  output  66 each  latched deltas.
REQ-015 o_done  output  1  one-cycle pulse when a triangle's walk completes.
REQ-016 o_tile_cnt  output  16  tiles transferred for current/last triangle.

Function
REQ-017 FSM states SHALL be IDLE, ALIGN, ISSUE, DONE.
REQ-018 IDLE: o_ready=1; on i_en && i_valid SHALL latch bbox, size, deltas, clear o_tile_cnt, go ALIGN.
REQ-019 i_tile_size not in {1,2,4,8,16} SHALL be latched as 16.
REQ-020 ALIGN (one cycle): start_x = xmin rounded down to tile-size multiple, start_y likewise; cur = start; if xmin>xmax or ymin>ymax go DONE, else ISSUE.
REQ-021 ISSUE: o_valid=1 with o_tile_x/y = cur; outputs SHALL hold stable until the edge where o_valid && i_ack.
REQ-022 Transfer on ack: o_tile_cnt increments; next = cur_x+size; if next_x > xmax then x = start_x, y = cur_y+size; if that y > ymax go DONE, else stay ISSUE.
REQ-023 Tile order SHALL be row-major, x fastest; back-to-back tiles SHALL sustain 1 tile/cycle with i_ack held high.
REQ-024 Latency: accept at edge N -> first o_valid=1 during cycle N+2.
REQ-025 Coordinate increment SHALL use COORD_W+1 bit arithmetic; overflow past 2^COORD_W-1 SHALL count as beyond max, never wrap.
REQ-026 DONE: o_done=1 for exactly one cycle, o_valid=0, then IDLE.
REQ-027 o_ready SHALL be 0 in ALIGN, ISSUE, DONE; i_valid there ignored.
REQ-028 i_en low SHALL only block acceptance in IDLE; it SHALL NOT drop an asserted o_valid.
REQ-029 i_ack while o_valid=0 SHALL be ignored.

Reset
REQ-030 rst=1 at any edge (including mid-walk) SHALL force IDLE; o_valid=0, o_done=0, o_ready=1, o_tile_cnt=0, o_tile_x/y=0, o_tile_size=0, deltas=0 from next cycle.
REQ-031 Triangle in flight at reset SHALL be discarded; no o_done issued for it.

Verification
REQ-032 bbox (0,0)-(15,15), size 8, i_ack=1 -> tiles (0,0),(8,0),(0,8),(8,8) on consecutive cycles, o_done next cycle, o_tile_cnt=4.
REQ-033 bbox (5,3)-(9,3), size 4 -> tiles (4,0),(8,0), o_done, cnt=2; size 5 input -> treated as 16, single tile (0,0).
REQ-034 bbox xmin=10 > xmax=2 -> no o_valid, o_done pulses cycle N+2 after accept, cnt=0.
REQ-035 i_ack low 3 cycles during ISSUE -> o_valid and all tile outputs unchanged; advance only on ack edge.
REQ-036 xmin=65528, xmax=65535, y 0-0, size 16 -> one tile (65520,0), no wrap, o_done.
REQ-037 rst pulse after 2nd of 4 tiles -> o_valid=0, o_ready=1 next cycle, no o_done, cnt=0.
